commit_unit: RTL

COMMIT_UNIT -- requirements
Module: commit_unit

---
 rtl/commit_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit
//
// Retires the instruction at the head of the reorder buffer, one at a time.
// ALU results are written to the register file in a single RETIRE cycle.
// Stores are presented to memory and held until memory acknowledges them,
// then retired in a single ST_RETIRE cycle. Every output comes from a
// register, so downstream logic sees clean, glitch-free strobes.
//
// Parameters
//   COUNT_WIDTH   width of the retired-instruction counter (wraps)
//
// Ports
//   clock         single clock, all state changes on the rising edge
//   reset         asynchronous, active-high
//   head_entry    ROB head entry (ROB_ENTRY struct)
//   head_ready    head entry has its value and address ready
//   head_tag      ROB tag of the head entry
//   mem_ack       memory accepted the current store
//   commit_pop    one-cycle pulse; ROB advances head at end of this cycle
//   rf_wr_en      register-file write strobe
//   rf_wr_idx     destination register
//   rf_wr_data    register-file write data
//   rf_wr_tag     tag being retired, for map-table clear
//   mem_req       store request, held until acknowledged
//   mem_addr      store address
//   mem_data      store data
//   mem_size      store size code copied from the entry
//   retired_count instructions retired since reset
//   store_busy    high while a store request is outstanding
// -----------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif

package commit_unit_pkg;

   typedef struct packed {
      logic              valid;
      logic              wr_mem;
      logic [4:0]        dest_reg;
      logic [`XLEN-1:0]  dest_addr;
      logic [`XLEN-1:0]  value;
      logic              store_dep;
      logic [2:0]        mem_size;
      logic              value_ready;
      logic              address_ready;
   } ROB_ENTRY;

endpackage

module commit_unit
   import commit_unit_pkg::*;
#(
   parameter int COUNT_WIDTH = 32
)
(
   input  logic                    clock,
   input  logic                    reset,
   input  ROB_ENTRY                head_entry,
   input  logic                    head_ready,
   input  logic [`ROB_TAG_LEN-1:0] head_tag,
   input  logic                    mem_ack,
   output logic                    commit_pop,
   output logic                    rf_wr_en,
   output logic [4:0]              rf_wr_idx,
   output logic [`XLEN-1:0]        rf_wr_data,
   output logic [`ROB_TAG_LEN-1:0] rf_wr_tag,
   output logic                    mem_req,
   output logic [`XLEN-1:0]        mem_addr,
   output logic [`XLEN-1:0]        mem_data,
   output logic [2:0]              mem_size,
   output logic [COUNT_WIDTH-1:0]  retired_count,
   output logic                    store_busy
);

   typedef enum logic [1:0] {
      IDLE,
      RETIRE,
      ST_REQ,
      ST_RETIRE
   } state_t;

   state_t                  state;
   logic [`ROB_TAG_LEN-1:0] store_tag;
   logic                    head_accept;
   logic                    unused_head_bits;

   // The per-field readiness bits and the store dependency are already
   // summarised by head_ready, so they are deliberately not consulted here.
   assign unused_head_bits = ^{head_entry.store_dep,
                               head_entry.value_ready,
                               head_entry.address_ready};

   // A head is only taken when it is both valid and fully ready.
   assign head_accept = head_entry.valid && head_ready;

   // Single Moore FSM. Outputs are loaded on the edge that enters a state so
   // they are valid for the whole cycle spent in that state. The head entry
   // is only sampled in IDLE; later states work from the latched copy held in
   // the output registers (and store_tag), so the ROB may change its head
   // freely once the pop has been issued. Data outputs are zeroed whenever
   // they are not meaningful so an idle unit shows no activity at all.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         store_tag     <= '0;
         commit_pop    <= 1'b0;
         rf_wr_en      <= 1'b0;
         rf_wr_idx     <= '0;
         rf_wr_data    <= '0;
         rf_wr_tag     <= '0;
         mem_req       <= 1'b0;
         mem_addr      <= '0;
         mem_data      <= '0;
         mem_size      <= '0;
         retired_count <= '0;
         store_busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (head_accept && !head_entry.wr_mem) begin
                  state         <= RETIRE;
                  commit_pop    <= 1'b1;
                  rf_wr_en      <= (head_entry.dest_reg != 5'd0);
                  rf_wr_idx     <= head_entry.dest_reg;
                  rf_wr_data    <= head_entry.value;
                  rf_wr_tag     <= head_tag;
                  retired_count <= retired_count + COUNT_WIDTH'(1);
               end else if (head_accept) begin
                  state      <= ST_REQ;
                  mem_req    <= 1'b1;
                  store_busy <= 1'b1;
                  mem_addr   <= head_entry.dest_addr;
                  mem_data   <= head_entry.value;
                  mem_size   <= head_entry.mem_size;
                  store_tag  <= head_tag;
               end
            end

            RETIRE: begin
               state      <= IDLE;
               commit_pop <= 1'b0;
               rf_wr_en   <= 1'b0;
               rf_wr_idx  <= '0;
               rf_wr_data <= '0;
               rf_wr_tag  <= '0;
            end

            ST_REQ: begin
               // The request fields stay untouched until memory accepts, so
               // they are stable for the whole time mem_req is high.
               if (mem_ack) begin
                  state         <= ST_RETIRE;
                  mem_req       <= 1'b0;
                  store_busy    <= 1'b0;
                  mem_addr      <= '0;
                  mem_data      <= '0;
                  mem_size      <= '0;
                  commit_pop    <= 1'b1;
                  rf_wr_tag     <= store_tag;
                  retired_count <= retired_count + COUNT_WIDTH'(1);
               end
            end

            ST_RETIRE: begin
               state      <= IDLE;
               commit_pop <= 1'b0;
               rf_wr_tag  <= '0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
